spike_collector: RTL and testbench

//   Sink stage directly downstream of the PE packetizer on the NoC ejection port at address
//   4'b1101 (memory wrapper). Accepts the 33-bit output-spike packets produced by every PE,

---
 rtl/spike_collector_if.sv | 30 +++
 rtl/spike_collector.sv | 128 ++++++++++++
 tb/tb_spike_collector.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/spike_collector_if.sv
// Packet ingress and row egress channels of the spike collector, plus its status flags.
// The slave modport is the collector; the master modport is whatever drives and drains it.
interface spike_collector_if #(
    parameter int PKT_W  = 33,
    parameter int ADDR_W = 4,
    parameter int OUTS   = 10,
    parameter int TS_W   = 4
);
    logic              pkt_valid;
    logic              pkt_ready;
    logic [PKT_W-1:0]  pkt_data;
    logic              row_valid;
    logic              row_ready;
    logic [OUTS-1:0]   row_data;
    logic [ADDR_W-1:0] row_pe;
    logic [TS_W-1:0]   row_ts;
    logic              ts_done;
    logic              all_done;
    logic              err;

    modport master (
        output pkt_valid, pkt_data, row_ready,
        input  pkt_ready, row_valid, row_data, row_pe, row_ts, ts_done, all_done, err
    );

    modport slave (
        input  pkt_valid, pkt_data, row_ready,
        output pkt_ready, row_valid, row_data, row_pe, row_ts, ts_done, all_done, err
    );
endinterface

// File: rtl/spike_collector.sv
// Collects per-PE output spikes from the NoC into a spike map and streams one row per PE
// at the end of each timestep; halts after NUM_TS timesteps.
module spike_collector #(
    parameter int PKT_W   = 33,
    parameter int ADDR_W  = 4,
    parameter int MY_ADDR = 13,
    parameter int NUM_PE  = 5,
    parameter int OUTS    = 10,
    parameter int NUM_TS  = 10,
    parameter int TS_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    spike_collector_if.slave  bus
);
    localparam int CNT_W = $clog2(OUTS + 1);
    localparam int PE_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [1:0] {COLLECT, DRAIN, CLOSE, HALT} state_t;

    state_t            state;
    logic [OUTS-1:0]   map [NUM_PE];
    logic [CNT_W-1:0]  cnt [NUM_PE];
    logic [PE_W-1:0]   idx;
    logic [TS_W-1:0]   ts;
    logic              err_q;

    logic              pkt_type;
    logic [ADDR_W-1:0] pkt_dest;
    logic [ADDR_W-1:0] pkt_src;
    logic              spike;
    logic              unused_data;

    assign pkt_type    = bus.pkt_data[PKT_W-1];
    assign pkt_dest    = bus.pkt_data[PKT_W-2 -: ADDR_W];
    assign pkt_src     = bus.pkt_data[PKT_W-2-ADDR_W -: ADDR_W];
    assign spike       = bus.pkt_data[0];
    assign unused_data = ^bus.pkt_data[PKT_W-2-2*ADDR_W:1];

    logic              pkt_fire;
    logic              row_fire;
    logic [NUM_PE-1:0] hit;
    logic              pkt_ok;
    logic              map_full_nxt;

    assign pkt_fire = bus.pkt_valid && bus.pkt_ready;
    assign row_fire = bus.row_valid && bus.row_ready;

    // hit[p] marks a well-formed packet from PE p that still has room; an out-of-range
    // src matches no p, so it falls into the error path with the other malformed cases.
    always_comb begin
        hit          = '0;
        map_full_nxt = 1'b1;
        for (int p = 0; p < NUM_PE; p++) begin
            if (!pkt_type && pkt_dest == ADDR_W'(MY_ADDR) && pkt_src == ADDR_W'(p) &&
                cnt[p] < CNT_W'(OUTS))
                hit[p] = 1'b1;
        end
        pkt_ok = |hit;
        for (int p = 0; p < NUM_PE; p++)
            map_full_nxt = map_full_nxt && ((cnt[p] + CNT_W'(hit[p])) == CNT_W'(OUTS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
            idx   <= '0;
            ts    <= '0;
            err_q <= 1'b0;
            for (int p = 0; p < NUM_PE; p++) begin
                map[p] <= '0;
                cnt[p] <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    if (pkt_fire) begin
                        if (pkt_ok) begin
                            for (int p = 0; p < NUM_PE; p++) begin
                                if (hit[p]) begin
                                    map[p][cnt[p]] <= spike;
                                    cnt[p]         <= cnt[p] + 1'b1;
                                end
                            end
                            if (map_full_nxt)
                                state <= DRAIN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (row_fire) begin
                        if (idx == PE_W'(NUM_PE - 1))
                            state <= CLOSE;
                        else
                            idx <= idx + 1'b1;
                    end
                end
                CLOSE: begin
                    idx <= '0;
                    for (int p = 0; p < NUM_PE; p++) begin
                        map[p] <= '0;
                        cnt[p] <= '0;
                    end
                    if (ts == TS_W'(NUM_TS - 1)) begin
                        state <= HALT;
                    end else begin
                        ts    <= ts + 1'b1;
                        state <= COLLECT;
                    end
                end
                HALT:    state <= HALT;
                default: state <= COLLECT;
            endcase
        end
    end

    // Outputs decode straight from registered state, so a stalled row stays stable.
    assign bus.pkt_ready = (state == COLLECT) && !rst;
    assign bus.row_valid = (state == DRAIN);
    assign bus.row_data  = (state == DRAIN) ? map[idx] : '0;
    assign bus.row_pe    = ADDR_W'(idx);
    assign bus.row_ts    = ts;
    assign bus.ts_done   = (state == CLOSE);
    assign bus.all_done  = (state == HALT);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_spike_collector.sv
// Randomized bench for spike_collector: a spike-map model built from the acceptance rules
// predicts every row, timestep boundary, error flag and halt.
module tb_spike_collector;
    localparam int NUM_PE  = 5;
    localparam int OUTS    = 10;
    localparam int NUM_TS  = 10;
    localparam int MY_ADDR = 13;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spike_collector_if bus ();
    spike_collector dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_err = 0;
    int ts_pulses = 0;

    logic [OUTS-1:0] exp_map [NUM_PE];
    int              exp_cnt [NUM_PE];
    logic            exp_err;
    int              exp_ts;
    logic            exp_halt;

    always @(negedge clk) if (bus.ts_done) ts_pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] mk_pkt(input bit typ, input int dest, input int src,
                                           input bit d);
        return {typ, 4'(dest), 4'(src), 23'($urandom), d};
    endfunction

    task automatic model_clear_map();
        for (int p = 0; p < NUM_PE; p++) begin
            exp_map[p] = '0;
            exp_cnt[p] = 0;
        end
    endtask

    task automatic model_reset();
        model_clear_map();
        exp_err  = 1'b0;
        exp_ts   = 0;
        exp_halt = 1'b0;
    endtask

    task automatic model_accept(input logic [32:0] p);
        int dest = int'(p[31:28]);
        int src  = int'(p[27:24]);
        if (p[32] == 1'b0 && dest == MY_ADDR && src < NUM_PE && exp_cnt[src] < OUTS) begin
            exp_map[src][exp_cnt[src]] = p[0];
            exp_cnt[src]++;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    function automatic bit model_full();
        for (int p = 0; p < NUM_PE; p++)
            if (exp_cnt[p] != OUTS) return 1'b0;
        return 1'b1;
    endfunction

    task automatic send(input logic [32:0] p);
        @(negedge clk);
        bus.pkt_valid = 1'b1;
        bus.pkt_data  = p;
        check("pkt_ready", 32'(bus.pkt_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.pkt_valid = 1'b0;
        model_accept(p);
        check("err", 32'(bus.err), 32'(exp_err));
    endtask

    task automatic send_random_good();
        int src;
        do src = $urandom_range(0, NUM_PE - 1); while (exp_cnt[src] == OUTS);
        send(mk_pkt(1'b0, MY_ADDR, src, 1'($urandom)));
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    endtask

    task automatic drain(input int stall_pe, input int stall_cycles, input bit rand_bp);
        for (int r = 0; r < NUM_PE; r++) begin
            int stalls = 0;
            bit done = 1'b0;
            while (!done) begin
                @(negedge clk);
                check("row_valid", 32'(bus.row_valid), 32'd1);
                check("row_pe", 32'(bus.row_pe), 32'(r));
                check("row_data", 32'(bus.row_data), 32'(exp_map[r]));
                check("row_ts", 32'(bus.row_ts), 32'(exp_ts));
                if (r == stall_pe && stalls < stall_cycles) bus.row_ready = 1'b0;
                else if (rand_bp && stalls < 4 && $urandom_range(0, 2) == 0) bus.row_ready = 1'b0;
                else bus.row_ready = 1'b1;
                if (bus.row_ready) done = 1'b1;
                else stalls++;
            end
        end
        @(negedge clk);
        bus.row_ready = 1'b0;
        check("ts_done", 32'(bus.ts_done), 32'd1);
        check("close_row_valid", 32'(bus.row_valid), 32'd0);
        check("err_sticky", 32'(bus.err), 32'(exp_err));
        model_clear_map();
        if (exp_ts == NUM_TS - 1) exp_halt = 1'b1;
        else exp_ts++;
        @(negedge clk);
        check("ts_done_pulse", 32'(bus.ts_done), 32'd0);
        check("all_done", 32'(bus.all_done), 32'(exp_halt));
        check("pkt_ready_next", 32'(bus.pkt_ready), 32'(!exp_halt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.pkt_valid = 1'b0;
        bus.row_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_pkt_ready", 32'(bus.pkt_ready), 32'd0);
            check("rst_row_valid", 32'(bus.row_valid), 32'd0);
        end
        rst = 1'b0;
        #1;
        model_reset();
        check("post_rst_pkt_ready", 32'(bus.pkt_ready), 32'd1);
        check("post_rst_row_valid", 32'(bus.row_valid), 32'd0);
        check("post_rst_row_data", 32'(bus.row_data), 32'd0);
        check("post_rst_row_pe", 32'(bus.row_pe), 32'd0);
        check("post_rst_row_ts", 32'(bus.row_ts), 32'd0);
        check("post_rst_ts_done", 32'(bus.ts_done), 32'd0);
        check("post_rst_all_done", 32'(bus.all_done), 32'd0);
        check("post_rst_err", 32'(bus.err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        int pulses_at_start;
        rst           = 1'b1;
        bus.pkt_valid = 1'b0;
        bus.pkt_data  = '0;
        bus.row_ready = 1'b0;
        model_reset();

        do_reset();
        pulses_at_start = ts_pulses;

        // Timestep 0: interleaved sources, alternating spike values -> rows 0101010101.
        for (int i = 0; i < NUM_PE * OUTS; i++)
            send(mk_pkt(1'b0, MY_ADDR, i % NUM_PE, ((i / NUM_PE) % 2) == 0));
        drain(-1, 0, 1'b0);

        // Timestep 1: random traffic, three-cycle stall on row 2.
        while (!model_full()) send_random_good();
        drain(2, 3, 1'b0);

        // Timestep 2: malformed and overflow packets are dropped and latch err.
        for (int i = 0; i < OUTS; i++) send(mk_pkt(1'b0, MY_ADDR, 0, 1'($urandom)));
        send(mk_pkt(1'b0, 4'b0011, 1, 1'b1));
        send(mk_pkt(1'b0, MY_ADDR, 7, 1'b1));
        send(mk_pkt(1'b1, MY_ADDR, 1, 1'b1));
        send(mk_pkt(1'b0, MY_ADDR, 0, ~exp_map[0][0]));
        check("err_set", 32'(bus.err), 32'd1);
        while (!model_full()) send_random_good();
        drain(-1, 0, 1'b1);

        // Remaining timesteps with random backpressure, ending in HALT.
        while (!exp_halt) begin
            while (!model_full()) send_random_good();
            drain(-1, 0, 1'b1);
        end
        check("ts_done_count", 32'(ts_pulses - pulses_at_start), 32'(NUM_TS));

        @(negedge clk);
        bus.pkt_valid = 1'b1;
        bus.pkt_data  = mk_pkt(1'b0, MY_ADDR, 0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            check("halt_pkt_ready", 32'(bus.pkt_ready), 32'd0);
            check("halt_all_done", 32'(bus.all_done), 32'd1);
            check("halt_row_valid", 32'(bus.row_valid), 32'd0);
        end
        bus.pkt_valid = 1'b0;

        // Reset in the middle of a timestep abandons it.
        do_reset();
        for (int i = 0; i < 23; i++) send_random_good();
        do_reset();
        repeat (3) begin
            @(negedge clk);
            check("abandon_row_valid", 32'(bus.row_valid), 32'd0);
        end
        while (!model_full()) send_random_good();
        drain(-1, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
